// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, fetches 16-bit words over req/valid and issues them to the decoder.
// Optional build macro IFU_PCSTACK_EN adds a call/return PC stack with sticky overflow/underflow flags.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
`ifdef IFU_PCSTACK_EN
  ,
  parameter int                STACK_DEPTH = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              pmem_req,
  output logic [ADDR_W-1:0] pmem_addr,
  input  logic [15:0]       pmem_rdata,
  input  logic              pmem_valid,
  output logic [15:0]       instruction,
  output logic [7:0]        OP_dk,
  output logic [3:0]        OP_s,
  output logic              instr_valid,
  input  logic [1:0]        pcInMux_ctrl,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              stall,
  input  logic              halt_req,
`ifdef IFU_PCSTACK_EN
  input  logic              call_push,
  output logic              stk_ovf,
  output logic              stk_unf,
`endif
  output logic              halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              retire;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign retire = (state_q == S_ISSUE) && !stall;

`ifdef IFU_PCSTACK_EN
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  // Circular LIFO: ptr_q is the next write slot, so a push while full overwrites the oldest entry.
  logic [ADDR_W-1:0] stk_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              stk_pop, stk_we;
  logic              stk_empty;

  assign ptr_inc   = (ptr_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec   = (ptr_q == '0) ? PTR_W'(STACK_DEPTH - 1) : ptr_q - PTR_W'(1);
  assign stk_empty = (cnt_q == '0);
  assign stk_pop   = retire && (pcInMux_ctrl == 2'b01);

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    stk_we = 1'b0;
    if (stk_pop) begin
      if (stk_empty) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (retire && call_push) begin
      stk_we = 1'b1;
      ptr_d  = ptr_inc;
      if (cnt_q == CNT_W'(STACK_DEPTH)) ovf_d = 1'b1;
      else                              cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: storage arrays are not reset; cnt_q alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (stk_we) stk_mem[ptr_q] <= pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
`endif

  always_comb begin
    unique case (pcInMux_ctrl)
      2'b11:   next_pc = pc_inc;
      2'b00:   next_pc = branch_target;
`ifdef IFU_PCSTACK_EN
      2'b01:   next_pc = stk_empty ? RESET_VEC : stk_mem[ptr_dec];
`else
      2'b01:   next_pc = acc_addr;
`endif
      default: next_pc = pc_q;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_FETCH, S_WAIT: begin
        if (pmem_valid) begin
          instr_d = pmem_rdata;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = halt_req ? S_HALT : S_FETCH;
        end
      end
      default: begin
        if (!halt_req) state_d = S_FETCH;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VEC;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Request is gated by rst_n so it stays low while reset is held even though the state is FETCH.
  assign pmem_req    = rst_n && ((state_q == S_FETCH) || (state_q == S_WAIT));
  assign pmem_addr   = pc_q;
  assign instruction = instr_q;
  assign OP_dk       = instr_q[15:8];
  assign OP_s        = instr_q[15:12];
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a program-memory responder with programmable latency,
// an expected-issue queue filled by the stimulus, and a monitor that checks every issue.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pmem_req;
  logic [11:0] pmem_addr;
  logic [15:0] pmem_rdata;
  logic        pmem_valid;
  logic [15:0] instruction;
  logic [7:0]  OP_dk;
  logic [3:0]  OP_s;
  logic        instr_valid;
  logic [1:0]  pcInMux_ctrl;
  logic [11:0] branch_target;
  logic [11:0] acc_addr;
  logic        stall;
  logic        halt_req;
  logic        halted;
`ifdef IFU_PCSTACK_EN
  logic        call_push;
  logic        stk_ovf;
  logic        stk_unf;
`endif

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pmem_req      (pmem_req),
    .pmem_addr     (pmem_addr),
    .pmem_rdata    (pmem_rdata),
    .pmem_valid    (pmem_valid),
    .instruction   (instruction),
    .OP_dk         (OP_dk),
    .OP_s          (OP_s),
    .instr_valid   (instr_valid),
    .pcInMux_ctrl  (pcInMux_ctrl),
    .branch_target (branch_target),
    .acc_addr      (acc_addr),
    .stall         (stall),
    .halt_req      (halt_req),
`ifdef IFU_PCSTACK_EN
    .call_push     (call_push),
    .stk_ovf       (stk_ovf),
    .stk_unf       (stk_unf),
`endif
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] word;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [4096];
  int          lat;
  int          wait_cnt;
  int          n_tests = 0;
  int          n_fails = 0;
  logic        prev_v  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_word(input logic [11:0] a);
    exp_t e;
    e.addr = a;
    e.word = mem[a];
    sb.push_back(e);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) check("issue_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  // Called at an issue edge: selects the next PC, queues the expected next word, waits for it.
  task automatic step(input logic [1:0] c, input logic [11:0] bt, input logic [11:0] nxt);
    pcInMux_ctrl  = c;
    branch_target = bt;
    expect_word(nxt);
    tick();
    wait_issue();
  endtask

  // Program-memory responder: answers a request after lat cycles, same cycle when lat is 0.
  always @(negedge clk) begin
    if (!rst_n || !pmem_req) begin
      pmem_valid = 1'b0;
      wait_cnt   = 0;
    end else if (wait_cnt >= lat) begin
      pmem_valid = 1'b1;
      pmem_rdata = mem[pmem_addr];
      wait_cnt   = 0;
    end else begin
      pmem_valid = 1'b0;
      wait_cnt++;
    end
  end

  // Monitor: each new issue must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (instr_valid && !prev_v) begin
        if (sb.size() == 0) begin
          check("unexpected_issue", {20'd0, pmem_addr}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("issue_addr", {20'd0, pmem_addr}, {20'd0, e.addr});
          check("issue_instr", {16'd0, instruction}, {16'd0, e.word});
          check("issue_op_dk", {24'd0, OP_dk}, {24'd0, e.word[15:8]});
          check("issue_op_s", {28'd0, OP_s}, {28'd0, e.word[15:12]});
        end
      end
      prev_v = instr_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'((i * 263) ^ 16'hC35A);
    mem[0] = 16'h6A05;
    mem[1] = 16'h0123;
    rst_n = 1'b0; pmem_valid = 1'b0; pmem_rdata = '0; lat = 0; wait_cnt = 0;
    pcInMux_ctrl = 2'b11; branch_target = '0; acc_addr = '0; stall = 1'b0; halt_req = 1'b0;
`ifdef IFU_PCSTACK_EN
    call_push = 1'b0;
`endif
    repeat (3) tick();
    check("rst_req", {31'd0, pmem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_instr", {16'd0, instruction}, 32'h0);
    check("rst_addr", {20'd0, pmem_addr}, 32'h0);

    @(posedge clk); #2 rst_n = 1'b1;
    #1 check("req_after_reset", {31'd0, pmem_req}, 32'd1);

    // Zero-wait memory, sequential fetch: an issue every second cycle.
    expect_word(12'h000);
    wait_issue();
    check("t1_op_dk_w0", {24'd0, OP_dk}, 32'h6A);
    check("t1_op_s_w0", {28'd0, OP_s}, 32'h6);
    for (int k = 1; k <= 2; k++) begin
      expect_word(12'(k));
      tick(); check("t1_gap", {31'd0, instr_valid}, 32'd0);
      tick(); check("t1_issue", {31'd0, instr_valid}, 32'd1);
      if (k == 1) check("t1_op_s_w1", {28'd0, OP_s}, 32'h0);
    end

    // Read data three cycles late: request and address held for four cycles.
    lat = 3;
    expect_word(12'h003);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_req_held", {31'd0, pmem_req}, 32'd1);
      check("t2_addr_held", {20'd0, pmem_addr}, 32'h003);
      check("t2_no_issue", {31'd0, instr_valid}, 32'd0);
    end
    tick(); check("t2_issue", {31'd0, instr_valid}, 32'd1);
    lat = 0;

    // Stall for five cycles with a pending branch.
    stall = 1'b1; pcInMux_ctrl = 2'b00; branch_target = 12'h3F0;
    expect_word(12'h3F0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_valid_held", {31'd0, instr_valid}, 32'd1);
      check("t3_instr_held", {16'd0, instruction}, {16'd0, mem[3]});
      check("t3_addr_held", {20'd0, pmem_addr}, 32'h003);
    end
    stall = 1'b0;
    tick();
    check("t3_branch_addr", {20'd0, pmem_addr}, 32'h3F0);
    check("t3_branch_req", {31'd0, pmem_req}, 32'd1);
    wait_issue();

    // PC wrap and repeat.
    step(2'b00, 12'hFFF, 12'hFFF);
    step(2'b11, 12'h000, 12'h000);
    step(2'b10, 12'h000, 12'h000);
`ifndef IFU_PCSTACK_EN
    acc_addr = 12'h055;
    step(2'b01, 12'h000, 12'h055);
`endif
    step(2'b00, 12'h020, 12'h020);

    // Halt at retire, then resume at the saved PC.
    pcInMux_ctrl = 2'b11; halt_req = 1'b1;
    tick();
    check("t5_halted", {31'd0, halted}, 32'd1);
    check("t5_no_req", {31'd0, pmem_req}, 32'd0);
    check("t5_no_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_saved_pc", {20'd0, pmem_addr}, 32'h021);
    tick();
    check("t5_still_halted", {31'd0, halted}, 32'd1);
    halt_req = 1'b0;
    expect_word(12'h021);
    tick();
    check("t5_resume_halted", {31'd0, halted}, 32'd0);
    check("t5_resume_req", {31'd0, pmem_req}, 32'd1);
    check("t5_resume_addr", {20'd0, pmem_addr}, 32'h021);
    wait_issue();

    // halt_req raised during a fetch and dropped before retire has no effect.
    expect_word(12'h022);
    tick();
    halt_req = 1'b1;
    tick();
    check("t5_fetch_halt_ignored", {31'd0, halted}, 32'd0);
    check("t5_fetch_halt_issue", {31'd0, instr_valid}, 32'd1);
    halt_req = 1'b0;

    // Asynchronous reset in the middle of a slow fetch.
    lat = 3;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, pmem_req}, 32'd0);
    check("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_mid_addr", {20'd0, pmem_addr}, 32'h000);
    lat = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    expect_word(12'h000);
    wait_issue();

`ifdef IFU_PCSTACK_EN
    // Five calls into a four-deep stack, then five returns.
    check("stk_ovf_clear", {31'd0, stk_ovf}, 32'd0);
    call_push = 1'b1;
    for (int i = 1; i <= 5; i++) step(2'b00, 12'(i * 256), 12'(i * 256));
    call_push = 1'b0;
    check("stk_ovf_set", {31'd0, stk_ovf}, 32'd1);
    check("stk_unf_clear", {31'd0, stk_unf}, 32'd0);
    for (int i = 4; i >= 1; i--) step(2'b01, 12'h000, 12'(i * 256 + 1));
    step(2'b01, 12'h000, 12'h000);
    check("stk_unf_set", {31'd0, stk_unf}, 32'd1);
`endif

    pcInMux_ctrl = 2'b10;
    stall = 1'b1;
    tick();
    check("queue_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
